// File: rtl/jtag_tap_fsm.sv
// IEEE 1149.1 TAP controller: 16-state FSM stepped by TMS on rising TCK.
// The state code is registered and drives the IR/DR capture/shift/update decode.
module jtag_tap_fsm #(
   parameter int FSM_SIZE = 4
) (
   input  logic                TCK,
   input  logic                TMS,
   input  logic                TRST,
   output logic [FSM_SIZE-1:0] state
);

   typedef enum logic [3:0] {
      TLR     = 4'd0,
      RTI     = 4'd1,
      SEL_DR  = 4'd2,
      CAP_DR  = 4'd3,
      SHF_DR  = 4'd4,
      EX1_DR  = 4'd5,
      PAU_DR  = 4'd6,
      EX2_DR  = 4'd7,
      UPD_DR  = 4'd8,
      SEL_IR  = 4'd9,
      CAP_IR  = 4'd10,
      SHF_IR  = 4'd11,
      EX1_IR  = 4'd12,
      PAU_IR  = 4'd13,
      EX2_IR  = 4'd14,
      UPD_IR  = 4'd15
   } tap_st_t;

   // Power-up value lands in Test-Logic-Reset even before TRST is applied.
   tap_st_t cur_st = TLR;
   tap_st_t nxt_st;

   always_ff @(posedge TCK) begin
      if (TRST) cur_st <= TLR;
      else      cur_st <= nxt_st;
   end

   always_comb begin
      nxt_st = TLR;
      case (cur_st)
         TLR:    nxt_st = TMS ? TLR    : RTI;
         RTI:    nxt_st = TMS ? SEL_DR : RTI;
         SEL_DR: nxt_st = TMS ? SEL_IR : CAP_DR;
         CAP_DR: nxt_st = TMS ? EX1_DR : SHF_DR;
         SHF_DR: nxt_st = TMS ? EX1_DR : SHF_DR;
         EX1_DR: nxt_st = TMS ? UPD_DR : PAU_DR;
         PAU_DR: nxt_st = TMS ? EX2_DR : PAU_DR;
         EX2_DR: nxt_st = TMS ? UPD_DR : SHF_DR;
         UPD_DR: nxt_st = TMS ? SEL_DR : RTI;
         SEL_IR: nxt_st = TMS ? TLR    : CAP_IR;
         CAP_IR: nxt_st = TMS ? EX1_IR : SHF_IR;
         SHF_IR: nxt_st = TMS ? EX1_IR : SHF_IR;
         EX1_IR: nxt_st = TMS ? UPD_IR : PAU_IR;
         PAU_IR: nxt_st = TMS ? EX2_IR : PAU_IR;
         EX2_IR: nxt_st = TMS ? UPD_IR : SHF_IR;
         UPD_IR: nxt_st = TMS ? SEL_DR : RTI;
         // Any unknown register content recovers to TLR on the next edge.
         default: nxt_st = TLR;
      endcase
   end

   assign state = cur_st;

endmodule

// File: tb/tb_jtag_tap_fsm.sv
// Scoreboard bench for jtag_tap_fsm: expected states queued at drive time,
// popped and compared one TCK edge later.
module tb_jtag_tap_fsm;

   logic       TCK = 1'b0;
   logic       TMS = 1'b1;
   logic       TRST = 1'b0;
   logic [3:0] state;

   int checks = 0;
   int errors = 0;
   logic [3:0] exp_q[$];

   jtag_tap_fsm #(.FSM_SIZE(4)) dut (
      .TCK  (TCK),
      .TMS  (TMS),
      .TRST (TRST),
      .state(state)
   );

   always #5 TCK = ~TCK;

   // Next-state tables from the TAP transition list (index = current state).
   const logic [3:0] nx0[16] = '{4'd1, 4'd1, 4'd3, 4'd4, 4'd4, 4'd6, 4'd6, 4'd4,
                                 4'd1, 4'd10, 4'd11, 4'd11, 4'd13, 4'd13, 4'd11, 4'd1};
   const logic [3:0] nx1[16] = '{4'd0, 4'd2, 4'd9, 4'd5, 4'd5, 4'd8, 4'd7, 4'd8,
                                 4'd2, 4'd0, 4'd12, 4'd12, 4'd15, 4'd14, 4'd15, 4'd2};
   // TMS walk from TLR to each state.
   const string path[16] = '{"", "0", "01", "010", "0100", "0101", "01010", "010101",
                             "01011", "011", "0110", "01100", "01101", "011010",
                             "0110101", "011011"};

   task automatic chk(input string tag, input logic [3:0] got, input logic [3:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic step(input string tag, input logic tms, input logic trst,
                       input logic [3:0] exp);
      logic [3:0] e;
      @(negedge TCK);
      TMS  = tms;
      TRST = trst;
      exp_q.push_back(exp);
      @(posedge TCK);
      #1;
      if (exp_q.size() == 0) begin
         chk({tag, "_q_empty"}, 4'd0, 4'd1);
      end else begin
         e = exp_q.pop_front();
         chk(tag, state, e);
      end
   endtask

   task automatic seq(input string tag, input logic [3:0] tms_bits [], input logic [3:0] exps []);
      for (int i = 0; i < tms_bits.size(); i++)
         step($sformatf("%s[%0d]", tag, i), tms_bits[i][0], 1'b0, exps[i]);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [3:0] cur;
      #2;
      chk("powerup", state, 4'd0);

      step("trst0", 1'b0, 1'b1, 4'd0);
      step("trst1", 1'b1, 1'b1, 4'd0);
      step("tlr_hold0", 1'b1, 1'b0, 4'd0);
      step("tlr_hold1", 1'b1, 1'b0, 4'd0);

      seq("ir_scan", '{0,1,1,0,0,1,1,0}, '{1,2,9,10,11,12,15,1});
      seq("dr_scan", '{1,0,0,0,1,0,1,1,0}, '{2,3,4,4,5,6,7,8,1});

      // RTI -> Shift-IR, then five TMS=1 edges back to TLR
      seq("to_shir", '{1,1,0,0}, '{2,9,10,11});
      seq("tms5", '{1,1,1,1,1,1}, '{12,15,2,9,0,0});

      // TRST asserted in Pause-DR: state holds until the edge
      seq("to_pdr", '{0,1,0,1,0}, '{1,2,3,5,6});
      @(negedge TCK);
      TMS  = 1'b0;
      TRST = 1'b1;
      #3;
      chk("trst_hold", state, 4'd6);
      step("trst_pdr", 1'b0, 1'b1, 4'd0);
      step("trst_rel", 1'b0, 1'b0, 4'd1);

      // Exhaustive transitions
      for (int s = 0; s < 16; s++) begin
         for (int t = 0; t < 2; t++) begin
            step("ex_rst", 1'b1, 1'b1, 4'd0);
            cur = 4'd0;
            for (int i = 0; i < path[s].len(); i++) begin
               logic b;
               b = (path[s][i] == "1");
               cur = b ? nx1[cur] : nx0[cur];
               step($sformatf("ex_walk_s%0d", s), b, 1'b0, cur);
            end
            chk($sformatf("ex_at_s%0d", s), state, s[3:0]);
            step($sformatf("ex_s%0d_t%0d", s, t), t[0], 1'b0,
                 t[0] ? nx1[s] : nx0[s]);
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
